// File: rtl/rect_anim_pkg.sv
// Shared types for the bouncing-rectangle animation controller: FSM states,
// pixel width type and a width clamp helper.
package rect_anim_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_GROW   = 3'd2,
    S_HOLD   = 3'd3,
    S_SHRINK = 3'd4
  } state_t;

  typedef logic [7:0] width_t;

  // Operands are 9 bits so an overshoot past 255 is still clamped correctly.
  function automatic width_t clamp_width(input logic [8:0] v,
                                         input logic [8:0] lo,
                                         input logic [8:0] hi);
    logic [8:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    clamp_width = r[7:0];
  endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Divides the frame strobe by FRAME_DIV; o_tick is combinational with the
// qualifying i_frame. Counter is held at zero while i_en is low.
module frame_tick_div #(
  parameter int FRAME_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_frame,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

  logic [7:0] cnt;

  assign o_tick = i_en && i_frame && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      cnt <= '0;
    end else if (i_frame) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rect_anim_ctrl.sv
// Per-frame sequencer for the bouncing rectangle: animate pulse, enable level
// and the grow/hold/shrink width effect. Outputs update 1 clk after the tick.
module rect_anim_ctrl
  import rect_anim_pkg::*;
#(
  parameter int FRAME_DIV   = 1,
  parameter int W_INIT      = 64,
  parameter int W_MAX       = 160,
  parameter int W_STEP      = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame,
  input  logic       i_run,
  input  logic       i_pulse_req,
  output logic       o_animate,
  output logic       o_go_animate,
  output logic [7:0] o_width,
  output logic [2:0] o_state,
  output logic       o_busy
);

  localparam logic [8:0]  INIT9     = 9'(W_INIT);
  localparam logic [8:0]  MAX9      = 9'(W_MAX);
  localparam logic [8:0]  STEP9     = 9'(W_STEP);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

  state_t      state, state_n;
  width_t      width_n;
  logic [15:0] hold_cnt, hold_n;
  logic        tick;
  logic        run_en;
  logic [8:0]  grown, shrunk;

  // Enable drops on the edge that leaves for IDLE, so the divider restarts clean.
  assign run_en = (state != S_IDLE) && i_run;

  frame_tick_div #(.FRAME_DIV(FRAME_DIV)) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (run_en),
    .i_frame (i_frame),
    .o_tick  (tick)
  );

  assign grown  = {1'b0, o_width} + STEP9;
  assign shrunk = ({1'b0, o_width} >= STEP9) ? {1'b0, o_width} - STEP9 : 9'd0;

  always_comb begin
    state_n = state;
    width_n = o_width;
    hold_n  = hold_cnt;
    if (state == S_IDLE) begin
      if (i_run) state_n = (o_width == width_t'(W_INIT)) ? S_MOVE : S_SHRINK;
    end else if (!i_run) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_MOVE: begin
          if (i_pulse_req) state_n = S_GROW;
        end
        S_GROW: begin
          if (tick) begin
            width_n = clamp_width(grown, INIT9, MAX9);
            if (width_n == width_t'(W_MAX)) begin
              state_n = S_HOLD;
              hold_n  = '0;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state_n = S_SHRINK;
              hold_n  = '0;
            end else begin
              hold_n = hold_cnt + 16'd1;
            end
          end
        end
        S_SHRINK: begin
          if (tick) begin
            width_n = clamp_width(shrunk, INIT9, MAX9);
            if (width_n == width_t'(W_INIT)) state_n = S_MOVE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_width      <= width_t'(W_INIT);
      hold_cnt     <= '0;
      o_animate    <= 1'b0;
      o_go_animate <= 1'b0;
    end else begin
      state        <= state_n;
      o_width      <= width_n;
      hold_cnt     <= hold_n;
      o_animate    <= tick;
      o_go_animate <= (state_n != S_IDLE);
    end
  end

  assign o_state = state;
  assign o_busy  = (state == S_GROW) || (state == S_HOLD) || (state == S_SHRINK);

endmodule
